// File: rtl/matrix_feed_controller.sv
// Reads a 4x4 row-major matrix from RAM and re-emits it as seven skewed wavefront
// vectors for a 4-lane systolic array; lane i carries column i delayed by i wavefronts.
module matrix_feed_controller #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16,
    parameter int BASE_ADDR  = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    output logic                               done,
    output logic [ADDR_WIDTH-1:0]              addr,
    input  logic [DATA_WIDTH-1:0]              data_in,
    output logic [0:6][0:3][DATA_WIDTH-1:0]    tpu_data_arr
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        BUILD,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    state_t                             r_state;
    state_t                             w_nextState;
    logic                               w_accept;
    logic [3:0]                         r_index;
    logic [3:0]                         w_indexNext;
    logic [ADDR_WIDTH-1:0]              r_addr;
    logic                               r_done;
    logic [DATA_WIDTH-1:0]              r_buf [0:15];
    logic [0:6][0:3][DATA_WIDTH-1:0]    r_tpu;
    logic [0:6][0:3][DATA_WIDTH-1:0]    w_build;

    assign done         = r_done;
    assign addr         = r_addr;
    assign tpu_data_arr = r_tpu;

    // The 4-bit index wraps to 0 after word 15, which also returns addr to BASE.
    assign w_indexNext = r_index + 4'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = LOAD;
                    w_accept    = 1'b1;
                end
            end
            LOAD: begin
                if (r_index == 4'd15) begin
                    w_nextState = BUILD;
                end
            end
            BUILD: begin
                w_nextState = DONE;
            end
            DONE: begin
                if (start) begin
                    w_nextState = LOAD;
                    w_accept    = 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Static skew wiring: entries outside the diagonal band are tied to zero.
    for (genvar d = 0; d < 7; d++) begin : g_wave
        for (genvar i = 0; i < 4; i++) begin : g_lane
            if (d >= i && d - i <= 3) begin : g_live
                assign w_build[d][i] = r_buf[(d - i) * 4 + i];
            end else begin : g_pad
                assign w_build[d][i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_index <= 4'd0;
            r_addr  <= BASE;
            r_done  <= 1'b0;
            r_buf   <= '{default: '0};
            r_tpu   <= '0;
        end else if (w_accept) begin
            r_index <= 4'd0;
            r_addr  <= BASE;
            r_done  <= 1'b0;
            r_buf   <= '{default: '0};
            r_tpu   <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    r_buf[r_index] <= data_in;
                    r_index        <= w_indexNext;
                    r_addr         <= BASE + ADDR_WIDTH'(w_indexNext);
                end
                BUILD: begin
                    r_tpu  <= w_build;
                    r_done <= 1'b1;
                    r_addr <= BASE;
                end
                default: begin
                    r_addr <= BASE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_feed_controller.sv
// Randomised self-checking bench for matrix_feed_controller against a lane-queue
// reference model of the wavefront skew.
module tb_matrix_feed_controller;

    localparam int AW = 6;
    localparam int DW = 16;

    logic                       clk = 1'b0;
    logic                       rst = 1'b0;
    logic                       start = 1'b0;
    logic                       done;
    logic [AW-1:0]              addr;
    logic [DW-1:0]              dataIn;
    logic [0:6][0:3][DW-1:0]    tpuDataArr;

    logic [DW-1:0]              ram [0:(1<<AW)-1];
    logic [DW-1:0]              expWave [0:6][0:3];
    int                         assertCount = 0;
    int                         failCount = 0;

    matrix_feed_controller #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .BASE_ADDR (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .done        (done),
        .addr        (addr),
        .data_in     (dataIn),
        .tpu_data_arr(tpuDataArr)
    );

    always #5 clk = ~clk;

    assign dataIn = ram[addr];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearModel();
        for (int d = 0; d < 7; d++)
            for (int i = 0; i < 4; i++)
                expWave[d][i] = '0;
    endtask

    // Each lane is i leading zeros, then column i top to bottom, then trailing zeros.
    task automatic buildModel();
        logic [DW-1:0] lane [$];
        for (int i = 0; i < 4; i++) begin
            lane.delete();
            repeat (i) lane.push_back('0);
            for (int r = 0; r < 4; r++) lane.push_back(ram[r * 4 + i]);
            while (lane.size() < 7) lane.push_back('0);
            for (int d = 0; d < 7; d++) expWave[d][i] = lane[d];
        end
    endtask

    task automatic checkArray(input string tag);
        for (int d = 0; d < 7; d++)
            for (int i = 0; i < 4; i++)
                checkOutput($sformatf("%s D%0d[%0d]", tag, d, i), 32'(tpuDataArr[d][i]), 32'(expWave[d][i]));
    endtask

    task automatic fillRandom();
        for (int k = 0; k < 16; k++) ram[k] = 16'($urandom);
    endtask

    // mode 0: one-cycle start pulse, 1: start toggled randomly mid-load, 2: start held high
    task automatic applyStimulus(input int mode);
        start = 1'b1;
        @(posedge clk); #1;
        clearModel();
        checkOutput("done after accept", 32'(done), 32'd0);
        checkArray("cleared");
        buildModel();
        for (int k = 0; k < 16; k++) begin
            checkOutput($sformatf("load addr %0d", k), 32'(addr), 32'(k));
            checkOutput($sformatf("load done %0d", k), 32'(done), 32'd0);
            start = (mode == 2) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); #1;
        end
        checkOutput("build addr", 32'(addr), 32'd0);
        checkOutput("build done", 32'(done), 32'd0);
        start = (mode == 2) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk); #1;
        checkOutput("done rise", 32'(done), 32'd1);
        checkOutput("done addr", 32'(addr), 32'd0);
        checkArray("result");
        if (mode != 2) start = 1'b0;
    endtask

    task automatic holdDone(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            checkOutput("hold done", 32'(done), 32'd1);
            checkOutput("hold addr", 32'(addr), 32'd0);
            checkArray("hold");
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [0:6][0:3][DW-1:0] basicTable;
        basicTable = {16'h1, 16'h0, 16'h0, 16'h0,
                      16'h5, 16'h2, 16'h0, 16'h0,
                      16'h9, 16'h6, 16'h3, 16'h0,
                      16'hd, 16'ha, 16'h7, 16'h4,
                      16'h0, 16'he, 16'hb, 16'h8,
                      16'h0, 16'h0, 16'hf, 16'hc,
                      16'h0, 16'h0, 16'h0, 16'h10};
        for (int k = 0; k < (1 << AW); k++) ram[k] = 16'($urandom);

        rst = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        clearModel();
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset addr", 32'(addr), 32'd0);
        checkArray("reset");
        repeat (6) @(posedge clk);
        #1;
        checkOutput("idle done", 32'(done), 32'd0);
        checkOutput("idle addr", 32'(addr), 32'd0);
        checkArray("idle");

        $display("[TB] basic load");
        for (int k = 0; k < 16; k++) ram[k] = 16'(k + 1);
        applyStimulus(0);
        for (int d = 0; d < 7; d++)
            for (int i = 0; i < 4; i++)
                checkOutput($sformatf("basic D%0d[%0d]", d, i), 32'(tpuDataArr[d][i]), 32'(basicTable[d][i]));
        holdDone(3);

        $display("[TB] restart");
        for (int k = 0; k < 16; k++) ram[k] = 16'(16'hFFFF - k);
        applyStimulus(0);
        checkOutput("restart D0[0]", 32'(tpuDataArr[0][0]), 32'h0000FFFF);
        checkOutput("restart D6[3]", 32'(tpuDataArr[6][3]), 32'h0000FFF0);

        $display("[TB] reset mid-load");
        fillRandom();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("mid addr", 32'(addr), 32'd8);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        clearModel();
        checkOutput("mid reset done", 32'(done), 32'd0);
        checkOutput("mid reset addr", 32'(addr), 32'd0);
        checkArray("mid reset");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("post reset idle", 32'(done), 32'd0);
        fillRandom();
        applyStimulus(0);

        $display("[TB] start held through done");
        fillRandom();
        applyStimulus(2);
        fillRandom();
        applyStimulus(1);

        $display("[TB] randomized loads");
        for (int n = 0; n < 8; n++) begin
            fillRandom();
            applyStimulus(int'($urandom_range(0, 1)));
            holdDone(int'($urandom_range(0, 4)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/matrix_feed_controller.md
# matrix_feed_controller

Loads one 4×4 matrix of DATA_WIDTH-bit words from a word-addressed RAM and reorders it into the skewed, diagonal wavefront format that a 4-lane systolic array (TPU) consumes. The block sits between the image/weight RAM and the systolic array. After a `start` pulse it reads 16 consecutive words, builds a 7×4 array of wavefront vectors, and raises `done`.

## Interface
Parameters:
- ADDR_WIDTH, default 6: RAM address width.
- DATA_WIDTH, default 16: element width.
- BASE_ADDR, default 0: RAM address of matrix element (0,0). Must satisfy BASE_ADDR+15 < 2^ADDR_WIDTH.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- start  in  1  begin a load; sampled only in IDLE or DONE.
- done  out  1  high while results are valid (DONE state).
- addr  out  ADDR_WIDTH  RAM read address (registered).
- data_in  in  DATA_WIDTH  RAM read data; combinational (same-cycle) read of `addr`.
- tpu_data_arr  out  DATA_WIDTH × [0:6][0:3]  wavefront d, lane i (registered).

## Operation
- Matrix layout is row-major: RAM word BASE_ADDR+k holds M[k/4][k%4], for k = 0..15.
- Output mapping: tpu_data_arr[d][i] = M[d−i][i] when 0 ≤ d−i ≤ 3, otherwise 0. Lane i therefore carries column i delayed by i wavefronts.
- FSM states: IDLE, LOAD, BUILD, DONE.
  - IDLE: addr = BASE_ADDR, done = 0. When start = 1, clear the internal 16-word buffer and tpu_data_arr to 0, set index = 0, and go to LOAD.
  - LOAD: addr = BASE_ADDR + index. Each cycle writes data_in into buffer[index] and increments index. After the write with index = 15, go to BUILD. start is ignored.
  - BUILD: one cycle. Computes all 28 tpu_data_arr entries from the buffer using the mapping above, then goes to DONE. start is ignored.
  - DONE: done = 1. tpu_data_arr holds its value. addr = BASE_ADDR. When start = 1, perform the same clearing as in IDLE and go to LOAD; done drops on that edge.
- Arithmetic: none. Data passes through unmodified, with DATA_WIDTH bits preserved.

## Timing
- Reset (rst = 0 at a rising edge): state = IDLE, done = 0, addr = BASE_ADDR, index = 0, buffer and all tpu_data_arr entries = 0. Reset has priority over everything, including mid-LOAD and mid-BUILD; any partial load is discarded.
- Let E0 be the edge at which start is sampled.
  - Edges E1..E16 capture words BASE_ADDR+0 .. BASE_ADDR+15. During the cycle ending at edge E(k+1), addr = BASE_ADDR+k.
  - Edge E17 updates tpu_data_arr, and done = 1 from E17 onward.
  - Latency from the start sample to done is 17 cycles.
- start is a level input. If it is held high through DONE, a new load begins at the first DONE edge, so done is high for exactly one cycle.
- tpu_data_arr changes only at the clearing edge (start accepted) and at the BUILD edge. It is stable at all times while done = 1.

## Test plan
- Reset: hold rst = 0 for 2 cycles, then release. Required: done = 0, addr = 0, all 28 tpu_data_arr entries = 0; with start = 0 the block stays in IDLE indefinitely.
- Basic load: RAM word k = k+1 (0x1..0x10), pulse start for 1 cycle. Required: done rises 17 edges after start is sampled; addr steps 0..15 on consecutive cycles.
- Wavefront contents, using the Basic load data:
  - D0 = {1,0,0,0}
  - D1 = {5,2,0,0}
  - D2 = {9,6,3,0}
  - D3 = {d,a,7,4}
  - D4 = {0,e,b,8}
  - D5 = {0,0,f,c}
  - D6 = {0,0,0,10}
- Restart: after DONE, change the RAM to word k = 0xFFFF−k and pulse start. Required: done drops on the accepting edge, tpu_data_arr clears to 0, and the new results appear (D0[0] = 0xFFFF, D6[3] = 0xFFF0) 17 cycles later.
- Reset mid-operation: apply rst = 0 while index = 8 in LOAD. Required: next state is IDLE, done = 0, addr = 0, all outputs 0; a subsequent start gives a correct full result.
- Ignored start: toggle start during LOAD and BUILD. Required: no effect on the address sequence, latency, or results.
